// File: rtl/axi_weight_wr_serializer_pkg.sv
// Shared constants, sizing helpers and serializer state encoding for the
// AXI-write to weight-RAM bridge.
package axi_weight_pkg;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_EMIT = 1'b1
   } ser_state_e;

   function automatic int lanes(input int data_w, input int weight_w);
      return data_w / weight_w;
   endfunction

   function automatic int lane_bytes(input int weight_w);
      return weight_w / 8;
   endfunction

   function automatic int word_width(input int addr_w, input int data_w);
      return addr_w - $clog2(data_w / 8);
   endfunction

   // Values for the default 32-bit address / 64-bit beat / 16-bit weight build.
   localparam int L      = lanes(64, 16);
   localparam int B      = lane_bytes(16);
   localparam int WORD_W = word_width(32, 64);
   localparam int MASK_W = L;

endpackage

// File: rtl/axi_weight_wr_serializer_if.sv
// AXI write-beat input and weight-RAM write output of the bridge.
interface axi_weight_wr_serializer_if #(
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int AXI_DATA_WIDTH = 64,
   parameter int WEIGHT_WIDTH   = 16
);
   logic [AXI_DATA_WIDTH-1:0]   axi_wr_data;
   logic [AXI_ADDR_WIDTH-1:0]   axi_wr_addr;
   logic [AXI_DATA_WIDTH/8-1:0] axi_wr_strobe;
   logic                        axi_wr_en;
   logic                        axi_wr_ready;
   logic [WEIGHT_WIDTH-1:0]     weight_wr_data;
   logic [31:0]                 weight_wr_addr;
   logic                        weight_wr_en;

   modport slave (
      input  axi_wr_data, axi_wr_addr, axi_wr_strobe, axi_wr_en,
      output axi_wr_ready, weight_wr_data, weight_wr_addr, weight_wr_en
   );

   modport master (
      output axi_wr_data, axi_wr_addr, axi_wr_strobe, axi_wr_en,
      input  axi_wr_ready, weight_wr_data, weight_wr_addr, weight_wr_en
   );
endinterface

// File: rtl/axi_weight_wr_serializer_fifo.sv
// Show-ahead FIFO (head visible on rdata_o) with occupancy count.
module weight_wr_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   localparam int CW   = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic [CW-1:0]    count_o,
   output logic             full_o,
   output logic             empty_o
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wptr_q, rptr_q;
   logic [CW-1:0]    count_q;
   logic             do_push, do_pop;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;
   assign rdata_o = mem_q[rptr_q];
   assign count_o = count_q;

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wptr_q] <= wdata_i;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) wptr_q <= wptr_q + 1'b1;
         if (do_pop)  rptr_q <= rptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end
endmodule

// File: rtl/axi_weight_wr_serializer.sv
// Buffers packed-weight AXI beats and writes them one weight per clock into
// the weight RAM. Optional macro WEIGHT_LOAD_DONE_EN adds the load_done output.
module axi_weight_wr_serializer
   import axi_weight_pkg::*;
#(
   parameter int NUM_WEIGHTS    = 76976,
   parameter int AXI_BASE_ADDR  = 393728,
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int AXI_DATA_WIDTH = 64,
   parameter int WEIGHT_WIDTH   = 16,
   parameter int FIFO_DEPTH     = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   axi_weight_wr_serializer_if.slave   bus
`ifdef WEIGHT_LOAD_DONE_EN
   ,
   output logic                        load_done
`endif
);
   localparam int NL  = lanes(AXI_DATA_WIDTH, WEIGHT_WIDTH);
   localparam int NB  = lane_bytes(WEIGHT_WIDTH);
   localparam int OFF = $clog2(AXI_DATA_WIDTH / 8);
   localparam int WW  = word_width(AXI_ADDR_WIDTH, AXI_DATA_WIDTH);
   localparam int LW  = $clog2(NL);
   localparam int EW  = WW + AXI_DATA_WIDTH + NL;
   // One spare bit so word*NL+i never wraps before the range compare.
   localparam int IW  = (((WW + LW) > 32) ? (WW + LW) : 32) + 1;
   localparam logic [IW-1:0]             NUM_W = IW'(NUM_WEIGHTS);
   localparam logic [AXI_ADDR_WIDTH-1:0] BASE  = AXI_ADDR_WIDTH'(AXI_BASE_ADDR);

   // Beat decode: NL is a power of two, so word*NL+i is {word, i}.
   logic [AXI_ADDR_WIDTH-1:0] rel_addr;
   logic [WW-1:0]             in_word;
   logic [NL-1:0]             in_mask;
   logic                      in_range;

   assign rel_addr = bus.axi_wr_addr - BASE;
   assign in_word  = WW'(rel_addr >> OFF);
   assign in_range = (bus.axi_wr_addr >= BASE);

   always_comb begin
      in_mask = '0;
      for (int i = 0; i < NL; i++)
         in_mask[i] = in_range && (&bus.axi_wr_strobe[i*NB +: NB]) &&
                      (IW'({in_word, LW'(i)}) < NUM_W);
   end

   logic [EW-1:0]             head;
   logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count;
   logic                      fifo_full, fifo_empty, push, pop;
   logic [WW-1:0]             h_word;
   logic [AXI_DATA_WIDTH-1:0] h_data;
   logic [NL-1:0]             h_mask;

   assign bus.axi_wr_ready = (fifo_count != FIFO_DEPTH[$bits(fifo_count)-1:0]);
   assign push = bus.axi_wr_en & ~fifo_full & (|in_mask);
   assign {h_word, h_data, h_mask} = head;

   weight_wr_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push),
      .wdata_i ({in_word, bus.axi_wr_data, in_mask}),
      .pop_i   (pop),
      .rdata_o (head),
      .count_o (fifo_count),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   ser_state_e                state_q, state_d;
   logic [WW-1:0]             word_q, word_d, src_word;
   logic [AXI_DATA_WIDTH-1:0] data_q, data_d, src_data;
   logic [NL-1:0]             rem_q, rem_d, src_mask, left;
   logic [LW-1:0]             lane;
   logic                      wen_q, wen_d;
   logic [WEIGHT_WIDTH-1:0]   wdata_q, wdata_d;
   logic [31:0]               waddr_q, waddr_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         word_q  <= '0;
         data_q  <= '0;
         rem_q   <= '0;
         wen_q   <= 1'b0;
         wdata_q <= '0;
         waddr_q <= '0;
      end else begin
         state_q <= state_d;
         word_q  <= word_d;
         data_q  <= data_d;
         rem_q   <= rem_d;
         wen_q   <= wen_d;
         wdata_q <= wdata_d;
         waddr_q <= waddr_d;
      end
   end

   // IDLE emits straight from the FIFO head; EMIT works off the held copy,
   // and reloads from the head on its last lane so entries run back to back.
   always_comb begin
      state_d  = state_q;
      word_d   = word_q;
      data_d   = data_q;
      rem_d    = rem_q;
      wen_d    = 1'b0;
      wdata_d  = wdata_q;
      waddr_d  = waddr_q;
      pop      = 1'b0;
      src_word = word_q;
      src_data = data_q;
      src_mask = rem_q;
      if (state_q == S_IDLE) begin
         src_word = h_word;
         src_data = h_data;
         src_mask = fifo_empty ? '0 : h_mask;
      end
      lane = '0;
      for (int i = NL - 1; i >= 0; i--)
         if (src_mask[i]) lane = LW'(i);
      left = src_mask & ~(NL'(1) << lane);
      if (src_mask != '0) begin
         wen_d   = 1'b1;
         wdata_d = src_data[lane*WEIGHT_WIDTH +: WEIGHT_WIDTH];
         waddr_d = 32'({src_word, lane});
         if (state_q == S_IDLE) begin
            pop    = 1'b1;
            word_d = h_word;
            data_d = h_data;
         end
         if (left != '0) begin
            rem_d   = left;
            state_d = S_EMIT;
         end else if (state_q == S_EMIT && !fifo_empty) begin
            pop     = 1'b1;
            word_d  = h_word;
            data_d  = h_data;
            rem_d   = h_mask;
            state_d = S_EMIT;
         end else begin
            rem_d   = '0;
            state_d = S_IDLE;
         end
      end
   end

   assign bus.weight_wr_en   = wen_q;
   assign bus.weight_wr_data = wdata_q;
   assign bus.weight_wr_addr = waddr_q;

`ifdef WEIGHT_LOAD_DONE_EN
   logic [31:0] wcnt_q, wcnt_d;
   logic        done_q;

   always_comb begin
      wcnt_d = wcnt_q;
      if (wen_q && wcnt_q != 32'(NUM_WEIGHTS)) wcnt_d = wcnt_q + 32'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wcnt_q <= '0;
         done_q <= 1'b0;
      end else begin
         wcnt_q <= wcnt_d;
         done_q <= (wcnt_d == 32'(NUM_WEIGHTS));
      end
   end

   assign load_done = done_q;
`endif
endmodule
